// File: rtl/m68k_dtack_gen.sv
// m68k_dtack_gen: 68000 DTACK/BERR generator with per-region wait states.
// Latency: dtack_n falls at start+1+WS (RAM/IO), ROM one cycle after data valid; registered outputs.
// Backpressure: the CPU holds AS_n low until dtack_n; AS_n rising aborts WAIT or ends ACK/ERR.
// Optional feature: define DTACK_TIMEOUT_EN to add the bus-error timeout (ERR state).
module m68k_dtack_gen #(
  parameter int unsigned WS_RAM  = 1,
  parameter int unsigned WS_IO   = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_as_n,
  input  logic prog_rom_cs,
  input  logic ram_cs,
  input  logic sprite_ram_cs,
  input  logic shared_ram_cs,
  input  logic io_cs,
  input  logic rom_data_valid,
  input  logic shared_ram_busy,
  output logic rom_req,
  output logic dtack_n,
  output logic berr_n,
  output logic busy
);

  localparam logic [7:0] WS_RAM_C = 8'(WS_RAM);
  localparam logic [7:0] WS_IO_C  = 8'(WS_IO);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
`ifdef DTACK_TIMEOUT_EN
    , S_ERR = 2'd3
`endif
  } state_t;

  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_ROM  = 3'd1,
    C_SHR  = 3'd2,
    C_RAM  = 3'd3,
    C_IO   = 3'd4
  } cls_t;

  state_t     state_q, state_nxt;
  cls_t       cls_q, cls_start;
  logic [7:0] cnt_q, cnt_load;
  logic       as_q;        // previous cpu_as_n, for falling-edge detection
  logic       armed;       // AS_n has been seen high since reset
  logic       first_q;     // first WAIT cycle after a start
  logic       rom_seen_q;  // rom_data_valid observed during this WAIT
  logic       start;
  logic       wait_done;
  logic       dtack_d, busy_d, rom_req_d;

`ifdef DTACK_TIMEOUT_EN
  localparam logic [7:0] TMO_C = 8'(TIMEOUT);
  logic [7:0] tmo_q;
  logic       berr_d;
`endif

  // A cycle starts only in IDLE on a fresh AS_n falling edge.
  assign start = (state_q == S_IDLE) && armed && as_q && !cpu_as_n;

  // Region class at start, priority ROM > shared > RAM/sprite > io > none; and its wait count.
  always_comb begin
    cls_start = C_NONE;
    cnt_load  = 8'd0;
    if (prog_rom_cs) begin
      cls_start = C_ROM;
    end else if (shared_ram_cs) begin
      cls_start = C_SHR;
      cnt_load  = WS_RAM_C;
    end else if (ram_cs || sprite_ram_cs) begin
      cls_start = C_RAM;
      cnt_load  = WS_RAM_C;
    end else if (io_cs) begin
      cls_start = C_IO;
      cnt_load  = WS_IO_C;
    end
  end

  // Completion condition of the WAIT state for the latched class.
  always_comb begin
    wait_done = 1'b0;
    case (cls_q)
      C_ROM:       wait_done = rom_seen_q;
      C_SHR:       wait_done = (cnt_q == 8'd0) && !shared_ram_busy;
      C_RAM, C_IO: wait_done = (cnt_q == 8'd0);
      default:     wait_done = 1'b0;
    endcase
  end

  // Next-state logic; AS_n release has priority over any completion.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: if (start) state_nxt = S_WAIT;
      S_WAIT: begin
        if (cpu_as_n)       state_nxt = S_IDLE;
        else if (wait_done) state_nxt = S_ACK;
`ifdef DTACK_TIMEOUT_EN
        else if (tmo_q + 8'd1 == TMO_C) state_nxt = S_ERR;
`endif
      end
      S_ACK:  if (cpu_as_n) state_nxt = S_IDLE;
`ifdef DTACK_TIMEOUT_EN
      S_ERR:  if (cpu_as_n) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state so registered outputs line up with the state.
  always_comb begin
    dtack_d   = (state_nxt != S_ACK);
    busy_d    = (state_nxt != S_IDLE);
    rom_req_d = (state_q == S_WAIT) && first_q && (cls_q == C_ROM);
`ifdef DTACK_TIMEOUT_EN
    berr_d    = (state_nxt != S_ERR);
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      dtack_n <= 1'b1;
      busy    <= 1'b0;
      rom_req <= 1'b0;
    end else begin
      state_q <= state_nxt;
      dtack_n <= dtack_d;
      busy    <= busy_d;
      rom_req <= rom_req_d;
    end
  end

`ifdef DTACK_TIMEOUT_EN
  // Bus-error output register.
  always_ff @(posedge clk) begin
    if (reset) berr_n <= 1'b1;
    else       berr_n <= berr_d;
  end
`else
  assign berr_n = 1'b1;
`endif

  // Datapath: AS_n history, class latch, wait counter and ROM-valid capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      as_q       <= 1'b1;
      armed      <= 1'b0;
      cls_q      <= C_NONE;
      cnt_q      <= 8'd0;
      first_q    <= 1'b0;
      rom_seen_q <= 1'b0;
    end else begin
      as_q  <= cpu_as_n;
      armed <= armed | cpu_as_n;
      if (start) begin
        cls_q      <= cls_start;
        cnt_q      <= cnt_load;
        first_q    <= 1'b1;
        rom_seen_q <= 1'b0;
      end else if (state_q == S_WAIT) begin
        first_q    <= 1'b0;
        rom_seen_q <= rom_seen_q | (rom_data_valid && cls_q == C_ROM);
        if (!(cls_q == C_SHR && shared_ram_busy) && cnt_q != 8'd0)
          cnt_q <= cnt_q - 8'd1;
      end else begin
        first_q <= 1'b0;
      end
    end
  end

`ifdef DTACK_TIMEOUT_EN
  // Timeout counter: cleared at start, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset)                 tmo_q <= 8'd0;
    else if (start)            tmo_q <= 8'd0;
    else if (state_q == S_WAIT) tmo_q <= tmo_q + 8'd1;
  end
`endif

endmodule

// File: tb/tb_m68k_dtack_gen.sv
// Directed bench for m68k_dtack_gen; cycle s is the state right after the edge that samples the start.
module tb_m68k_dtack_gen;

  logic clk = 1'b0;
  logic reset, cpu_as_n, prog_rom_cs, ram_cs, sprite_ram_cs, shared_ram_cs, io_cs;
  logic rom_data_valid, shared_ram_busy;
  logic rom_req, dtack_n, berr_n, busy;
  int checks = 0;
  int errors = 0;

  m68k_dtack_gen #(.WS_RAM(1), .WS_IO(2), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .cpu_as_n(cpu_as_n), .prog_rom_cs(prog_rom_cs),
    .ram_cs(ram_cs), .sprite_ram_cs(sprite_ram_cs), .shared_ram_cs(shared_ram_cs),
    .io_cs(io_cs), .rom_data_valid(rom_data_valid), .shared_ram_busy(shared_ram_busy),
    .rom_req(rom_req), .dtack_n(dtack_n), .berr_n(berr_n), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bus idle with AS_n high for a few cycles.
  task automatic idle_bus();
    cpu_as_n = 1'b1; prog_rom_cs = 1'b0; ram_cs = 1'b0; sprite_ram_cs = 1'b0;
    shared_ram_cs = 1'b0; io_cs = 1'b0; rom_data_valid = 1'b0; shared_ram_busy = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_bus();
    checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL reset_dtack: got %b want 1", dtack_n); end
    checks++; if (berr_n !== 1'b1) begin errors++; $display("FAIL reset_berr: got %b want 1", berr_n); end
    checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL reset_rom_req: got %b want 0", rom_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_ram();
    idle_bus();
    cpu_as_n = 1'b0; ram_cs = 1'b1;
    step(); // s
    checks++; if (busy !== 1'b1 || dtack_n !== 1'b1) begin errors++; $display("FAIL ram_s0: busy=%b dtack_n=%b want 1/1", busy, dtack_n); end
    step(); // s+1
    checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL ram_s1: dtack_n=%b want 1", dtack_n); end
    step(); // s+2
    checks++; if (dtack_n !== 1'b0) begin errors++; $display("FAIL ram_s2: dtack_n=%b want 0", dtack_n); end
    repeat (3) step(); // s+5, AS_n still low
    checks++; if (dtack_n !== 1'b0) begin errors++; $display("FAIL ram_hold: dtack_n=%b want 0", dtack_n); end
    cpu_as_n = 1'b1; ram_cs = 1'b0;
    step();
    checks++; if (dtack_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ram_release: dtack_n=%b busy=%b want 1/0", dtack_n, busy); end
  endtask

  task automatic test_rom();
    idle_bus();
    rom_data_valid = 1'b1; // stale valid in IDLE must be ignored
    step();
    rom_data_valid = 1'b0; cpu_as_n = 1'b0; prog_rom_cs = 1'b1;
    step(); // s
    checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL rom_req_s0: got %b want 0", rom_req); end
    step(); // s+1
    checks++; if (rom_req !== 1'b1) begin errors++; $display("FAIL rom_req_s1: got %b want 1", rom_req); end
    step(); // s+2
    checks++; if (rom_req !== 1'b0 || dtack_n !== 1'b1) begin errors++; $display("FAIL rom_s2: rom_req=%b dtack_n=%b want 0/1", rom_req, dtack_n); end
    repeat (7) step(); // s+9
    rom_data_valid = 1'b1;
    step(); // s+10 samples valid
    rom_data_valid = 1'b0;
    checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL rom_s10: dtack_n=%b want 1", dtack_n); end
    step(); // s+11
    checks++; if (dtack_n !== 1'b0) begin errors++; $display("FAIL rom_s11: dtack_n=%b want 0", dtack_n); end
    cpu_as_n = 1'b1; prog_rom_cs = 1'b0;
    step();
    checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL rom_release: dtack_n=%b want 1", dtack_n); end
  endtask

  task automatic test_shared();
    idle_bus();
    cpu_as_n = 1'b0; shared_ram_cs = 1'b1; ram_cs = 1'b1; shared_ram_busy = 1'b1;
    step(); // s
    repeat (5) step(); // s+5, busy sampled through this edge
    shared_ram_busy = 1'b0;
    checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL shr_s5: dtack_n=%b want 1", dtack_n); end
    step(); // s+6
    checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL shr_s6: dtack_n=%b want 1", dtack_n); end
    step(); // s+7
    checks++; if (dtack_n !== 1'b0) begin errors++; $display("FAIL shr_s7: dtack_n=%b want 0", dtack_n); end
    cpu_as_n = 1'b1;
    step();
  endtask

  task automatic test_io_abort();
    idle_bus();
    cpu_as_n = 1'b0; io_cs = 1'b1;
    step(); // s
    step(); // s+1
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL io_busy: got %b want 1", busy); end
    cpu_as_n = 1'b1; io_cs = 1'b0;
    step(); // s+2 abort
    checks++; if (busy !== 1'b0 || dtack_n !== 1'b1) begin errors++; $display("FAIL io_abort: busy=%b dtack_n=%b want 0/1", busy, dtack_n); end
    step(); // s+3, where the ACK would have been
    checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL io_abort_s3: dtack_n=%b want 1", dtack_n); end
  endtask

  task automatic test_abort_vs_expiry();
    idle_bus();
    cpu_as_n = 1'b0; sprite_ram_cs = 1'b1;
    step(); // s
    step(); // s+1
    cpu_as_n = 1'b1; // sampled on the same edge the counter expires
    step(); // s+2
    checks++; if (dtack_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_expiry: dtack_n=%b busy=%b want 1/0", dtack_n, busy); end
  endtask

  task automatic test_priority();
    idle_bus();
    cpu_as_n = 1'b0; ram_cs = 1'b1; io_cs = 1'b1; // RAM timing wins over io
    step(); step(); step(); // s+2
    checks++; if (dtack_n !== 1'b0) begin errors++; $display("FAIL prio_ram_io: dtack_n=%b want 0", dtack_n); end
    idle_bus();
    cpu_as_n = 1'b0; prog_rom_cs = 1'b1; ram_cs = 1'b1; // ROM wins: request, no early ack
    step(); step(); // s+1
    checks++; if (rom_req !== 1'b1) begin errors++; $display("FAIL prio_rom_req: got %b want 1", rom_req); end
    step(); // s+2
    checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL prio_rom_ack: dtack_n=%b want 1", dtack_n); end
    cpu_as_n = 1'b1;
    step();
  endtask

  task automatic test_no_select();
    logic saw_dtack;
    idle_bus();
    saw_dtack = 1'b0;
    cpu_as_n = 1'b0;
    step(); // s
`ifdef DTACK_TIMEOUT_EN
    for (int i = 0; i < 254; i++) begin
      step();
      if (dtack_n !== 1'b1) saw_dtack = 1'b1;
    end // s+254
    checks++; if (berr_n !== 1'b1) begin errors++; $display("FAIL tmo_s254: berr_n=%b want 1", berr_n); end
    step(); // s+255
    checks++; if (berr_n !== 1'b0) begin errors++; $display("FAIL tmo_s255: berr_n=%b want 0", berr_n); end
    repeat (3) step();
    checks++; if (berr_n !== 1'b0 || saw_dtack || dtack_n !== 1'b1) begin errors++; $display("FAIL tmo_hold: berr_n=%b dtack_seen=%b want 0/0", berr_n, saw_dtack); end
    cpu_as_n = 1'b1;
    step();
    checks++; if (berr_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL tmo_release: berr_n=%b busy=%b want 1/0", berr_n, busy); end
`else
    begin
      logic saw_berr;
      saw_berr = 1'b0;
      for (int i = 0; i < 300; i++) begin
        step();
        if (dtack_n !== 1'b1) saw_dtack = 1'b1;
        if (berr_n !== 1'b1) saw_berr = 1'b1;
      end
      checks++; if (saw_dtack || busy !== 1'b1) begin errors++; $display("FAIL nosel_wait: dtack_seen=%b busy=%b want 0/1", saw_dtack, busy); end
      checks++; if (saw_berr) begin errors++; $display("FAIL nosel_berr: berr_low_seen=%b want 0", saw_berr); end
    end
    cpu_as_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nosel_release: busy=%b want 0", busy); end
`endif
  endtask

  task automatic test_reset_in_ack();
    idle_bus();
    cpu_as_n = 1'b0; ram_cs = 1'b1;
    step(); step(); step(); // s+2 in ACK
    checks++; if (dtack_n !== 1'b0) begin errors++; $display("FAIL rst_ack_pre: dtack_n=%b want 0", dtack_n); end
    reset = 1'b1;
    step();
    checks++; if (dtack_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_ack: dtack_n=%b busy=%b want 1/0", dtack_n, busy); end
    reset = 1'b0;
    begin
      logic saw_busy;
      saw_busy = 1'b0;
      for (int i = 0; i < 5; i++) begin
        step();
        if (busy !== 1'b0 || dtack_n !== 1'b1) saw_busy = 1'b1;
      end
      checks++; if (saw_busy) begin errors++; $display("FAIL rst_held_as: activity=%b want 0", saw_busy); end
    end
    cpu_as_n = 1'b1;
    step(); step();
    cpu_as_n = 1'b0;
    step(); step(); step(); // s+2 of a fresh start
    checks++; if (dtack_n !== 1'b0) begin errors++; $display("FAIL rst_restart: dtack_n=%b want 0", dtack_n); end
    cpu_as_n = 1'b1; ram_cs = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    cpu_as_n = 1'b1; prog_rom_cs = 1'b0; ram_cs = 1'b0; sprite_ram_cs = 1'b0;
    shared_ram_cs = 1'b0; io_cs = 1'b0; rom_data_valid = 1'b0; shared_ram_busy = 1'b0;
    test_reset();
    test_ram();
    test_rom();
    test_shared();
    test_io_abort();
    test_abort_vs_expiry();
    test_priority();
    test_no_select();
    test_reset_in_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m68k_dtack_gen.md
M68K_DTACK_GEN -- requirements
Module: m68k_dtack_gen

Interface
REQ-001 SHALL have parameter WS_RAM, default 1: wait cycles for ram_cs, sprite_ram_cs and shared_ram_cs (0-255).
REQ-002 SHALL have parameter WS_IO, default 2: wait cycles for io_cs (0-255).
REQ-003 SHALL have parameter TIMEOUT, default 255: WAIT cycles before bus error (only when DTACK_TIMEOUT_EN is defined).
REQ-004 SHALL have port clk  in  1  the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port cpu_as_n  in  1  68K address strobe, active-low.
REQ-007 SHALL have port prog_rom_cs  in  1  program ROM region decoded.
REQ-008 SHALL have port ram_cs  in  1  work RAM region decoded.
REQ-009 SHALL have port sprite_ram_cs  in  1  sprite RAM region decoded.
REQ-010 SHALL have port shared_ram_cs  in  1  Z80 shared RAM region decoded.
REQ-011 SHALL have port io_cs  in  1  OR of all register, palette and scroll selects.
REQ-012 SHALL have port rom_data_valid  in  1  SDRAM ROM read data ready.
REQ-013 SHALL have port shared_ram_busy  in  1  Z80 currently owns the shared RAM.
REQ-014 SHALL have port rom_req  out  1  one-cycle ROM fetch request pulse.
REQ-015 SHALL have port dtack_n  out  1  68K data acknowledge, active-low.
REQ-016 SHALL have port berr_n  out  1  68K bus error, active-low.
REQ-017 SHALL have port busy  out  1  high while state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, WAIT, ACK and ERR, with all outputs registered.
REQ-019 SHALL register cpu_as_n every cycle; a cycle start is defined as cpu_as_n == 0 with the registered previous value == 1.
REQ-020 On a cycle start in IDLE, SHALL latch the region class with priority ROM > shared > RAM/sprite > io > none, then enter WAIT.
REQ-021 SHALL load an 8-bit wait counter on entry to WAIT: WS_RAM for RAM/sprite/shared, WS_IO for io, 0 otherwise.
REQ-022 SHALL drive rom_req high for exactly the one cycle after a ROM-class start.
REQ-023 ROM class: SHALL leave WAIT for ACK in the cycle after rom_data_valid is sampled high while in WAIT; rom_data_valid seen in IDLE SHALL be ignored.
REQ-024 Shared class: SHALL hold the counter while shared_ram_busy == 1, decrement otherwise, and enter ACK when the counter is 0 and shared_ram_busy == 0.
REQ-025 RAM/sprite/io class: SHALL decrement the counter each WAIT cycle and enter ACK when the counter is 0, so dtack_n falls at start+1+WS (WS = 0 gives ACK one cycle after the start).
REQ-026 None class (no select): SHALL remain in WAIT and never assert dtack_n, subject to REQ-033.
REQ-027 In ACK, SHALL hold dtack_n = 0 until cpu_as_n is sampled 1, then return to IDLE with dtack_n = 1 on the next cycle.
REQ-028 If cpu_as_n is sampled 1 while in WAIT, SHALL abort to IDLE without asserting dtack_n; abort SHALL win over a simultaneous rom_data_valid or counter expiry.
REQ-029 A new start while dtack_n is still low SHALL NOT be possible; a start SHALL only be recognised in IDLE.

Reset
REQ-030 While reset == 1 at a rising edge, SHALL force state IDLE, dtack_n = 1, berr_n = 1, rom_req = 0, busy = 0, counters 0 and the registered cpu_as_n = 1.
REQ-031 Reset asserted mid-cycle (WAIT/ACK/ERR) SHALL take effect at the next edge with no further acknowledge.
REQ-032 After reset release with cpu_as_n already 0, SHALL NOT start a cycle until cpu_as_n has been seen 1.

Configuration
REQ-033 With DTACK_TIMEOUT_EN defined, SHALL count WAIT cycles in an 8-bit counter and, when the count reaches TIMEOUT, enter ERR with berr_n = 0 held until cpu_as_n is sampled 1, then go to IDLE.
REQ-034 Without DTACK_TIMEOUT_EN, SHALL tie berr_n to 1, omit the timeout counter and the ERR state, and let unmapped cycles wait indefinitely.

Verification
REQ-035 RAM access, WS_RAM = 1: AS_n falls at cycle 10 -> dtack_n low at cycle 12, high one cycle after AS_n rises.
REQ-036 ROM access with rom_data_valid at cycle 20, start at cycle 10 -> rom_req high in cycle 11 only; dtack_n low at cycle 21.
REQ-037 Shared access with shared_ram_busy high for cycles 10-15, start at cycle 10, WS_RAM = 1 -> dtack_n low no earlier than cycle 17.
REQ-038 io access, WS_IO = 2, AS_n raised at start+2 -> abort; dtack_n stays 1 and busy drops.
REQ-039 No select with DTACK_TIMEOUT_EN, TIMEOUT = 255 -> berr_n low after 255 WAIT cycles, dtack_n stays 1; without the macro, berr_n is constant 1.
REQ-040 Reset pulsed during ACK -> dtack_n = 1 the next cycle; held AS_n low produces no new start.
